// File: rtl/mem_bus_initiator.sv
// mem_bus_initiator
//   Bus initiator for the MMIO slave interface. Takes one command at a time
//   over a valid/ready channel, runs a single or incrementing burst of word
//   reads or writes on the slave bus, and returns read data / completion on a
//   valid/ready response channel.
//
//   Optional feature: define BUS_INIT_RANGE_CHECK_EN to check every beat
//   address against the legal map {0x2000..0x2FFC, 0x7F00, 0x7F20}. An
//   out-of-range beat is not issued (no write strobe, read data forced to 0)
//   and rsp_err stays set until the next command is accepted. Without the
//   macro every beat is issued and rsp_err is always 0.
//
// Ports
//   clk, rstn               clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only while idle)
//   cmd_we/addr/wdata/len   command fields, sampled at the accept edge
//   bus_addr/wdata/we       slave address, write data and write strobe
//   bus_rdata               slave read data (combinational on bus_addr)
//   rsp_valid/rsp_ready     response handshake
//   rsp_data/last/err       read word or beat count, last flag, range error
module mem_bus_initiator #(
  parameter int          LEN_W     = 8,
  parameter logic [31:0] ADDR_STEP = 32'd4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [31:0]      cmd_addr,
  input  logic [31:0]      cmd_wdata,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [31:0]      bus_addr,
  output logic [31:0]      bus_wdata,
  output logic             bus_we,
  input  logic [31:0]      bus_rdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_last,
  output logic             rsp_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W:0]   beat_cnt_r;   // beats already completed in this command
  logic [31:0]      bus_addr_r;
  logic [31:0]      bus_wdata_r;
  logic             bus_we_r;
  logic             rsp_valid_r;
  logic [31:0]      rsp_data_r;
  logic             rsp_last_r;
  logic             rsp_err_r;

  logic [31:0]      start_addr_s;
  logic [31:0]      next_addr_s;
  logic [LEN_W:0]   cnt_inc_s;
  logic [LEN_W:0]   len_plus1_s;
  logic             last_beat_s;
  logic             ok_start_s;
  logic             ok_next_s;
  logic             ok_cur_s;
  logic             unused_addr_lsb_s;

  assign start_addr_s      = {cmd_addr[31:2], 2'b00};
  assign next_addr_s       = bus_addr_r + ADDR_STEP;   // wraps at 2^32
  assign cnt_inc_s         = beat_cnt_r + {{LEN_W{1'b0}}, 1'b1};
  assign len_plus1_s       = {1'b0, len_r} + {{LEN_W{1'b0}}, 1'b1};
  assign last_beat_s       = (beat_cnt_r == {1'b0, len_r});
  assign unused_addr_lsb_s = ^cmd_addr[1:0];

`ifdef BUS_INIT_RANGE_CHECK_EN
  function automatic logic addr_in_map(input logic [31:0] a);
    return ((a >= 32'h0000_2000) && (a <= 32'h0000_2FFC)) ||
           (a == 32'h0000_7F00) || (a == 32'h0000_7F20);
  endfunction

  // Writes check the address that will be presented next cycle; reads check
  // the address being presented now, at the capture edge.
  assign ok_start_s = addr_in_map(start_addr_s);
  assign ok_next_s  = addr_in_map(next_addr_s);
  assign ok_cur_s   = addr_in_map(bus_addr_r);
`else
  assign ok_start_s = 1'b1;
  assign ok_next_s  = 1'b1;
  assign ok_cur_s   = 1'b1;
`endif

  assign cmd_ready = (state_r == IDLE);
  assign bus_addr  = bus_addr_r;
  assign bus_wdata = bus_wdata_r;
  assign bus_we    = bus_we_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_last  = rsp_last_r;
  assign rsp_err   = rsp_err_r;

  // Command FSM with registered bus and response outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      len_r       <= {LEN_W{1'b0}};
      beat_cnt_r  <= {(LEN_W+1){1'b0}};
      bus_addr_r  <= 32'd0;
      bus_wdata_r <= 32'd0;
      bus_we_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 32'd0;
      rsp_last_r  <= 1'b0;
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid) begin
            bus_addr_r  <= start_addr_s;
            bus_wdata_r <= cmd_wdata;
            len_r       <= cmd_len;
            beat_cnt_r  <= {(LEN_W+1){1'b0}};
            if (cmd_we) begin
              state_r   <= WRITE;
              bus_we_r  <= ok_start_s;
              rsp_err_r <= ~ok_start_s;
            end else begin
              state_r   <= READ;
              rsp_err_r <= 1'b0;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        WRITE: begin
          beat_cnt_r <= cnt_inc_s;
          if (last_beat_s) begin
            bus_we_r    <= 1'b0;
            rsp_valid_r <= 1'b1;
            rsp_data_r  <= {{(31-LEN_W){1'b0}}, cnt_inc_s};
            rsp_last_r  <= 1'b1;
            state_r     <= RESP;
          end else begin
            bus_addr_r <= next_addr_s;
            bus_we_r   <= ok_next_s;
            rsp_err_r  <= rsp_err_r | ~ok_next_s;
          end
        end
        READ: begin
          beat_cnt_r  <= cnt_inc_s;
          rsp_valid_r <= 1'b1;
          rsp_last_r  <= last_beat_s;
          rsp_data_r  <= ok_cur_s ? bus_rdata : 32'd0;
          rsp_err_r   <= rsp_err_r | ~ok_cur_s;
          state_r     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            // Only read bursts can come back here with beats outstanding.
            if (beat_cnt_r != len_plus1_s) begin
              bus_addr_r <= next_addr_s;
              state_r    <= READ;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r  <= IDLE;
          bus_we_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_initiator.sv
// tb_mem_bus_initiator
//   Randomized bench for mem_bus_initiator. A word-array slave answers the
//   bus; a reference model derives each command's expected write beats and
//   responses from the burst rules (start address, +4 per beat, beat count,
//   address map when range checking is compiled in).
module tb_mem_bus_initiator;

  localparam int LEN_W = 8;
`ifdef BUS_INIT_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic             clk;
  logic             rstn;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_we;
  logic [31:0]      cmd_addr;
  logic [31:0]      cmd_wdata;
  logic [LEN_W-1:0] cmd_len;
  logic [31:0]      bus_addr;
  logic [31:0]      bus_wdata;
  logic             bus_we;
  logic [31:0]      bus_rdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic             rsp_last;
  logic             rsp_err;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        err;
    int          cyc;
  } rsp_t;

  wr_t         wr_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] slave_mem [1024];
  logic [31:0] model_mem [1024];
  bit          slave_wr_en;
  int          cyc;
  int          n_checks;
  int          n_pass;

  bit          stall_prev;
  logic [31:0] prev_data;
  logic [31:0] prev_addr;
  logic        prev_last;

  mem_bus_initiator #(.LEN_W(LEN_W), .ADDR_STEP(32'd4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_len   (cmd_len),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_rdata (bus_rdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .rsp_err   (rsp_err)
  );

  // The slave aliases every 4 KB window onto 1024 words.
  assign bus_rdata = slave_mem[bus_addr[11:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle stamp: number of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit in_map(input logic [31:0] a);
    return !RANGE_EN ||
           ((a >= 32'h0000_2000) && (a <= 32'h0000_2FFC)) ||
           (a == 32'h0000_7F00) || (a == 32'h0000_7F20);
  endfunction

  // Bus monitor and slave: records write beats and response handshakes,
  // and checks that a stalled response and the bus stay frozen.
  always @(negedge clk) begin
    if (!rstn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 32'(rsp_valid), 32'd1);
        check("hold_data", rsp_data, prev_data);
        check("hold_last", 32'(rsp_last), 32'(prev_last));
        check("hold_addr", bus_addr, prev_addr);
        check("hold_no_we", 32'(bus_we), 32'd0);
      end
      if (bus_we) begin
        wr_q.push_back('{bus_addr, bus_wdata, cyc});
        if (slave_wr_en) slave_mem[bus_addr[11:2]] = bus_wdata;
      end
      if (rsp_valid && rsp_ready) rsp_q.push_back('{rsp_data, rsp_last, rsp_err, cyc});
      stall_prev = rsp_valid && !rsp_ready;
      prev_data  = rsp_data;
      prev_last  = rsp_last;
      prev_addr  = bus_addr;
    end
  end

  // mode 0: rsp_ready always high; 1: random; 2: low for 5 cycles, then high.
  task automatic run_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int len, input int mode);
    int          n;
    int          acc;
    int          beats;
    int          k;
    logic [31:0] a0;
    logic [31:0] ai;
    logic [31:0] exp_d;
    logic        err_acc;
    bit          ok;
    beats = len + 1;
    a0    = {addr[31:2], 2'b00};
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    wr_q.delete();
    rsp_q.delete();
    rsp_ready = (mode != 2);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_len   = len[LEN_W-1:0];
    @(posedge clk); #1;
    acc = cyc;
    // Scramble the fields: they must have been captured at the accept edge.
    cmd_valid = 1'b0;
    cmd_we    = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_len   = LEN_W'($urandom);
    n = 0;
    while (!cmd_ready && n < 4 * beats + 50) begin
      case (mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = ($urandom_range(0, 3) != 0);
        default: rsp_ready = (n >= 5);
      endcase
      @(posedge clk); #1; n++;
    end
    rsp_ready = 1'b1;
    check("cmd_done_in_budget", 32'(cmd_ready), 32'd1);
    err_acc = 1'b0;
    if (we) begin
      k = 0;
      for (int i = 0; i < beats; i++) begin
        ai = a0 + 32'(i) * 32'd4;
        if (in_map(ai)) begin
          if (k < wr_q.size()) begin
            check("wr_addr", wr_q[k].addr, ai);
            check("wr_data", wr_q[k].data, wdata);
            if (mode == 0) check("wr_cycle", 32'(wr_q[k].cyc), 32'(acc + i));
          end
          k++;
          model_mem[ai[11:2]] = wdata;
        end else begin
          err_acc = 1'b1;
        end
      end
      check("wr_beat_count", 32'(wr_q.size()), 32'(k));
      check("wr_rsp_count", 32'(rsp_q.size()), 32'd1);
      if (rsp_q.size() > 0) begin
        check("wr_rsp_data", rsp_q[0].data, 32'(beats));
        check("wr_rsp_last", 32'(rsp_q[0].last), 32'd1);
        check("wr_rsp_err", 32'(rsp_q[0].err), 32'(err_acc));
        if (mode == 0) check("wr_rsp_cycle", 32'(rsp_q[0].cyc), 32'(acc + beats));
      end
      if (mode == 0) check("wr_duration", 32'(cyc - acc), 32'(beats + 1));
    end else begin
      check("rd_no_we", 32'(wr_q.size()), 32'd0);
      check("rd_rsp_count", 32'(rsp_q.size()), 32'(beats));
      for (int i = 0; i < beats; i++) begin
        ai      = a0 + 32'(i) * 32'd4;
        ok      = in_map(ai);
        err_acc = err_acc | !ok;
        exp_d   = ok ? model_mem[ai[11:2]] : 32'd0;
        if (i < rsp_q.size()) begin
          check("rd_data", rsp_q[i].data, exp_d);
          check("rd_last", 32'(rsp_q[i].last), 32'(i == len));
          check("rd_err", 32'(rsp_q[i].err), 32'(err_acc));
          if (mode == 0) check("rd_cycle", 32'(rsp_q[i].cyc), 32'(acc + 2 * i + 1));
        end
      end
      if (mode == 0) check("rd_duration", 32'(cyc - acc), 32'(2 * beats));
    end
  endtask

  initial begin
    logic [31:0] v;
    n_checks    = 0;
    n_pass      = 0;
    rstn        = 1'b0;
    cmd_valid   = 1'b0;
    cmd_we      = 1'b0;
    cmd_addr    = 32'd0;
    cmd_wdata   = 32'd0;
    cmd_len     = '0;
    rsp_ready   = 1'b0;
    slave_wr_en = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      slave_mem[i] = v;
      model_mem[i] = v;
    end

    #3;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_last", 32'(rsp_last), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;

    run_cmd(1'b1, 32'h0000_2000, 32'hA5A5_A5A5, 3, 0);
    run_cmd(1'b0, 32'h0000_2000, 32'd0, 3, 0);
    run_cmd(1'b0, 32'h0000_2004, 32'd0, 1, 2);
    run_cmd(1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 1, 0);
    run_cmd(1'b0, 32'hFFFF_FFFC, 32'd0, 1, 1);
    run_cmd(1'b1, 32'h0000_7F00, 32'h0BAD_F00D, 0, 0);
    run_cmd(1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 0, 0);
    run_cmd(1'b0, 32'h0000_7F00, 32'd0, 0, 0);
    run_cmd(1'b1, 32'h0000_2013, 32'hC0FF_EE00, 2, 1);
    run_cmd(1'b0, 32'h0000_2010, 32'd0, 2, 2);
    run_cmd(1'b1, 32'h0000_2400, 32'h5A5A_0F0F, 255, 0);
    run_cmd(1'b0, 32'h0000_2400, 32'd0, 255, 1);

    for (int t = 0; t < 40; t++) begin
      run_cmd(1'($urandom), 32'h0000_1F80 + $urandom_range(0, 32'h440) * 32'd4 + $urandom_range(0, 3),
              $urandom, int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
    end

    // Reset in the middle of a long write burst: strobe drops at once and
    // the burst is abandoned without a response.
    slave_wr_en = 1'b0;
    wr_q.delete();
    rsp_q.delete();
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_addr  = 32'h0000_2800;
    cmd_wdata = 32'h7777_7777;
    cmd_len   = 8'd20;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("midrst_we_before", 32'(bus_we), 32'd1);
    rstn = 1'b0;
    #1;
    check("midrst_we_dropped", 32'(bus_we), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    #2;
    rstn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("postrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("postrst_no_rsp", 32'(rsp_q.size()), 32'd0);
    check("postrst_beats", 32'(wr_q.size()), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
